pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 22 ++
 rtl/pipe_ctrl_if.sv | 26 ++
 rtl/pipe_hold_wdog.sv | 38 +++
 rtl/pipe_ctrl.sv | 102 ++++++++++
 tb/tb_pipe_ctrl.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-hold definitions: hold levels, controller state encoding and
// the level-combining helper used by pipe_ctrl and the pipe registers.
package pipe_ctrl_pkg;

  typedef logic [2:0] hold_lvl_t;

  // Downstream registers treat any level >= HOLD_IF as a hold of that stage
  localparam hold_lvl_t HOLD_NONE = 3'b000;
  localparam hold_lvl_t HOLD_PC   = 3'b001;
  localparam hold_lvl_t HOLD_IF   = 3'b010;
  localparam hold_lvl_t HOLD_ID   = 3'b011;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } pipe_state_t;

  function automatic hold_lvl_t hold_max(input hold_lvl_t a, input hold_lvl_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Jump/stall request and hold/redirect response bundle between execute,
// the hazard sources and the pipeline controller.
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic        jump_req_i;
  logic [31:0] jump_addr_i;
  logic        hold_ex_req_i;
  logic        hold_int_req_i;
  logic        hold_bus_req_i;
  hold_lvl_t   hold_flag_o;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;
  logic        hold_timeout_o;

  modport master (
    output jump_req_i, jump_addr_i, hold_ex_req_i, hold_int_req_i, hold_bus_req_i,
    input  hold_flag_o, jump_flag_o, jump_addr_o, hold_timeout_o
  );

  modport slave (
    input  jump_req_i, jump_addr_i, hold_ex_req_i, hold_int_req_i, hold_bus_req_i,
    output hold_flag_o, jump_flag_o, jump_addr_o, hold_timeout_o
  );

endinterface

// File: rtl/pipe_hold_wdog.sv
// Full-pipeline hold watchdog: counts consecutive stall cycles, saturating at
// LIMIT, and raises a sticky timeout flag when the count reaches LIMIT.
module pipe_hold_wdog #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stall_i,
  output logic timeout_o
);

  localparam logic [15:0] LIMIT_W = 16'(LIMIT);

  logic [15:0] cnt_r;
  logic        timeout_r;

  // Stall-run counter with saturation; sticky flag set as the count lands on LIMIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r     <= 16'd0;
      timeout_r <= 1'b0;
    end else begin
      if (stall_i) begin
        if (cnt_r != LIMIT_W) begin
          cnt_r <= cnt_r + 16'd1;
        end
        if (cnt_r >= (LIMIT_W - 16'd1)) begin
          timeout_r <= 1'b1;
        end
      end else begin
        cnt_r <= 16'd0;
      end
    end
  end

  assign timeout_o = timeout_r;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hold/redirect controller: jump flush FSM plus stall level merge.
// Define PIPE_CTRL_WDOG_EN to include the full-pipeline hold watchdog.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned WDOG_LIMIT   = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_ctrl_if.slave  bus
);

  localparam logic       FLUSH_MULTI  = (FLUSH_CYCLES > 32'd1);
  localparam logic [3:0] FLUSH_RELOAD = FLUSH_MULTI ? 4'(FLUSH_CYCLES - 32'd2) : 4'd0;

  if ((FLUSH_CYCLES < 32'd1) || (FLUSH_CYCLES > 32'd15)) begin : g_bad_flush
    $error("pipe_ctrl: FLUSH_CYCLES out of range 1..15");
  end
  if ((WDOG_LIMIT < 32'd2) || (WDOG_LIMIT > 32'd65535)) begin : g_bad_wdog
    $error("pipe_ctrl: WDOG_LIMIT out of range 2..65535");
  end

  pipe_state_t state_r;
  logic [3:0]  flush_cnt_r;
  hold_lvl_t   flush_lvl_s;
  hold_lvl_t   stall_lvl_s;
  logic        stall_full_s;

  // Flush sequencer: a jump (re)arms the countdown, stalls never freeze it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      flush_cnt_r <= 4'd0;
    end else if (bus.jump_req_i) begin
      if (FLUSH_MULTI) begin
        state_r     <= ST_FLUSH;
        flush_cnt_r <= FLUSH_RELOAD;
      end else begin
        state_r     <= ST_IDLE;
        flush_cnt_r <= 4'd0;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r     <= ST_IDLE;
          flush_cnt_r <= 4'd0;
        end
        ST_FLUSH: begin
          if (flush_cnt_r == 4'd0) begin
            state_r <= ST_IDLE;
          end else begin
            flush_cnt_r <= flush_cnt_r - 4'd1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          flush_cnt_r <= 4'd0;
        end
      endcase
    end
  end

  // Flush and stall levels; a multi-cycle op or interrupt entry freezes everything
  always_comb begin
    flush_lvl_s = HOLD_NONE;
    stall_lvl_s = HOLD_NONE;
    if (bus.jump_req_i || (state_r == ST_FLUSH)) begin
      flush_lvl_s = HOLD_IF;
    end else begin
      flush_lvl_s = HOLD_NONE;
    end
    if (bus.hold_ex_req_i || bus.hold_int_req_i) begin
      stall_lvl_s = HOLD_ID;
    end else if (bus.hold_bus_req_i) begin
      stall_lvl_s = HOLD_PC;
    end else begin
      stall_lvl_s = HOLD_NONE;
    end
  end

  assign stall_full_s    = (stall_lvl_s == HOLD_ID);
  assign bus.hold_flag_o = hold_max(flush_lvl_s, stall_lvl_s);
  assign bus.jump_flag_o = bus.jump_req_i;
  assign bus.jump_addr_o = bus.jump_req_i ? bus.jump_addr_i : 32'h0000_0000;

`ifdef PIPE_CTRL_WDOG_EN
  pipe_hold_wdog #(
    .LIMIT (WDOG_LIMIT)
  ) u_wdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall_i   (stall_full_s),
    .timeout_o (bus.hold_timeout_o)
  );
`else
  logic unused_s;
  assign unused_s           = stall_full_s;
  assign bus.hold_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: two instances (FLUSH_CYCLES 2 and 3) share
// stimulus; expected levels are queued per vector and checked mid-cycle.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_ctrl_if if2();
  pipe_ctrl_if if3();

  pipe_ctrl #(.FLUSH_CYCLES(2), .WDOG_LIMIT(1024)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
  pipe_ctrl #(.FLUSH_CYCLES(3), .WDOG_LIMIT(1024)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

  typedef struct {
    string       name;
    hold_lvl_t   h2;
    hold_lvl_t   h3;
    logic        jf;
    logic [31:0] addr;
    logic        to;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic exp_to = 1'b0;

  task automatic drive(input logic jr, input logic [31:0] a, input logic ex,
                       input logic it, input logic bs);
    if2.jump_req_i = jr; if2.jump_addr_i = a; if2.hold_ex_req_i = ex;
    if2.hold_int_req_i = it; if2.hold_bus_req_i = bs;
    if3.jump_req_i = jr; if3.jump_addr_i = a; if3.hold_ex_req_i = ex;
    if3.hold_int_req_i = it; if3.hold_bus_req_i = bs;
  endtask

  task automatic push(input string name, input logic jr, input logic [31:0] a,
                      input hold_lvl_t h2, input hold_lvl_t h3);
    exp_t e;
    e.name = name; e.h2 = h2; e.h3 = h3; e.jf = jr;
    e.addr = jr ? a : 32'h0; e.to = exp_to;
    sb.push_back(e);
  endtask

  task automatic check_now();
    exp_t e;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty got 0 entries need 1");
      return;
    end
    e = sb.pop_front();
    vectors++;
    if (if2.hold_flag_o !== e.h2) begin
      miscompares++; $display("FAIL %s hold2 got %b exp %b", e.name, if2.hold_flag_o, e.h2);
    end
    if (if3.hold_flag_o !== e.h3) begin
      miscompares++; $display("FAIL %s hold3 got %b exp %b", e.name, if3.hold_flag_o, e.h3);
    end
    if ((if2.jump_flag_o !== e.jf) || (if3.jump_flag_o !== e.jf)) begin
      miscompares++;
      $display("FAIL %s jump_flag got %b/%b exp %b", e.name, if2.jump_flag_o, if3.jump_flag_o, e.jf);
    end
    if ((if2.jump_addr_o !== e.addr) || (if3.jump_addr_o !== e.addr)) begin
      miscompares++;
      $display("FAIL %s jump_addr got %h/%h exp %h", e.name, if2.jump_addr_o, if3.jump_addr_o, e.addr);
    end
    if ((if2.hold_timeout_o !== e.to) || (if3.hold_timeout_o !== e.to)) begin
      miscompares++;
      $display("FAIL %s timeout got %b/%b exp %b", e.name, if2.hold_timeout_o, if3.hold_timeout_o, e.to);
    end
  endtask

  // One clock cycle: drive after the edge, compare at the falling edge
  task automatic step(input string name, input logic jr, input logic [31:0] a,
                      input logic ex, input logic it, input logic bs,
                      input hold_lvl_t h2, input hold_lvl_t h3);
    drive(jr, a, ex, it, bs);
    push(name, jr, a, h2, h3);
    @(negedge clk);
    check_now();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    push("reset_idle", 1'b0, 32'h0, HOLD_NONE, HOLD_NONE);
    check_now();
    drive(1'b1, 32'h0000_0040, 1'b0, 1'b0, 1'b0);
    #1;
    push("reset_jump", 1'b1, 32'h0000_0040, HOLD_IF, HOLD_IF);
    check_now();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("post_reset", 1'b0, 32'h1234_5678, 1'b0, 1'b0, 1'b0, HOLD_NONE, HOLD_NONE);
  endtask

  task automatic test_jump();
    step("jump_c0", 1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0, HOLD_IF,   HOLD_IF);
    step("jump_c1", 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, HOLD_IF,   HOLD_IF);
    step("jump_c2", 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, HOLD_NONE, HOLD_IF);
    step("jump_c3", 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, HOLD_NONE, HOLD_NONE);
  endtask

  task automatic test_back_to_back();
    step("b2b_j1", 1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0, HOLD_IF,   HOLD_IF);
    step("b2b_j2", 1'b1, 32'h0000_0200, 1'b0, 1'b0, 1'b0, HOLD_IF,   HOLD_IF);
    step("b2b_c1", 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, HOLD_IF,   HOLD_IF);
    step("b2b_c2", 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, HOLD_NONE, HOLD_IF);
    step("b2b_c3", 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, HOLD_NONE, HOLD_NONE);
  endtask

  task automatic test_stall_overlap();
    step("bus_only",  1'b0, 32'h0, 1'b0, 1'b0, 1'b1, HOLD_PC, HOLD_PC);
    step("int_only",  1'b0, 32'h0, 1'b0, 1'b1, 1'b0, HOLD_ID, HOLD_ID);
    step("ex_bus",    1'b0, 32'h0, 1'b1, 1'b0, 1'b1, HOLD_ID, HOLD_ID);
    step("jump_bus",  1'b1, 32'h0000_0180, 1'b0, 1'b0, 1'b1, HOLD_IF, HOLD_IF);
    step("ex_flush",  1'b0, 32'h0, 1'b1, 1'b0, 1'b0, HOLD_ID, HOLD_ID);
    step("bus_flush", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, HOLD_PC, HOLD_IF);
    step("released",  1'b0, 32'h0, 1'b0, 1'b0, 1'b0, HOLD_NONE, HOLD_NONE);
  endtask

  task automatic test_watchdog();
    exp_to = 1'b0;
`ifdef PIPE_CTRL_WDOG_EN
    repeat (1023) step("wdog_run1", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, HOLD_ID, HOLD_ID);
    step("wdog_gap1", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, HOLD_NONE, HOLD_NONE);
    repeat (1023) step("wdog_run2", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, HOLD_ID, HOLD_ID);
    step("wdog_gap2", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, HOLD_NONE, HOLD_NONE);
    repeat (1024) step("wdog_run3", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, HOLD_ID, HOLD_ID);
    exp_to = 1'b1;
    repeat (3) step("wdog_sticky", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, HOLD_NONE, HOLD_NONE);
`else
    repeat (5000) step("nowdog_run", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, HOLD_ID, HOLD_ID);
    step("nowdog_rel", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, HOLD_NONE, HOLD_NONE);
`endif
  endtask

  task automatic test_flush_reset();
    step("fr_jump", 1'b1, 32'h0000_0300, 1'b0, 1'b0, 1'b0, HOLD_IF, HOLD_IF);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    rst_n  = 1'b0;
    exp_to = 1'b0;
    #1;
    push("fr_in_reset", 1'b0, 32'h0, HOLD_NONE, HOLD_NONE);
    check_now();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("fr_after", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, HOLD_NONE, HOLD_NONE);
    step("fr_jump2", 1'b1, 32'h0000_0400, 1'b0, 1'b0, 1'b0, HOLD_IF, HOLD_IF);
    step("fr_tail",  1'b0, 32'h0, 1'b0, 1'b0, 1'b0, HOLD_IF, HOLD_IF);
  endtask

  initial begin
    test_reset();
    test_jump();
    test_back_to_back();
    test_stall_overlap();
    test_watchdog();
    test_flush_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
